// File: rtl/ring_node_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_node_adapter_pkg
// Description : Shared network definitions for the ring interconnect: node-id
//               width, memory address width and the packet format carried
//               between ring nodes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ring_node_adapter_pkg;

  localparam int ID_SIZE = 2;    // log2 of the ring node count
  localparam int ADDR_W  = 48;   // memory address width

  typedef struct packed {
    logic [ID_SIZE-1:0] src;
    logic [ID_SIZE-1:0] dest;
    logic [ADDR_W-1:0]  memoryAddress;
  } pkt_t;

endpackage
`default_nettype wire

// File: rtl/ring_node_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : ring_node_adapter_if
// Description : Bundles the core request/response handshakes, the ring node
//               injection/delivery signals and the FIFO status outputs.
// Ports       : master - core + ring side (drives requests and deliveries)
//               slave  - adapter side
// Revision    : 1.0 - initial release
// ============================================================================
interface ring_node_adapter_if
  import ring_node_adapter_pkg::*;
#(
  parameter int NUM_PROC  = 4,
  parameter int INJ_DEPTH = 8,
  parameter int EJ_DEPTH  = 8
);
  localparam int DW = $clog2(NUM_PROC);
  localparam int IW = $clog2(INJ_DEPTH) + 1;
  localparam int EW = $clog2(EJ_DEPTH) + 1;

  // core request
  logic              req_valid;
  logic [DW-1:0]     req_dest;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  // ring injection
  pkt_t              packetSendIn;
  logic              packetCoreIn;
  logic              recievedOut;
  // ring delivery
  logic              recieved;
  pkt_t              packetRecieved;
  // core response
  logic              resp_valid;
  logic [DW-1:0]     resp_src;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_ready;
  // status
  logic [IW-1:0]     inj_count;
  logic [EW-1:0]     ej_count;
  logic              ej_overflow;

  modport master (
    output req_valid, req_dest, req_addr, recievedOut, recieved, packetRecieved, resp_ready,
    input  req_ready, packetSendIn, packetCoreIn, resp_valid, resp_src, resp_addr,
           inj_count, ej_count, ej_overflow
  );

  modport slave (
    input  req_valid, req_dest, req_addr, recievedOut, recieved, packetRecieved, resp_ready,
    output req_ready, packetSendIn, packetCoreIn, resp_valid, resp_src, resp_addr,
           inj_count, ej_count, ej_overflow
  );

endinterface
`default_nettype wire

// File: rtl/ring_node_adapter_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. The head output is
//               driven from storage registers and forced to zero when empty.
//               A push into a full FIFO is taken only if a pop happens in the
//               same cycle.
// Ports       : clk, rst_l (async active-low)
//               i_push/i_din  - write request and data
//               i_pop         - remove head (ignored when empty)
//               o_dout        - head entry
//               o_full/o_empty/o_count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8   // power of two, >= 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_l,
  input  wire logic                   i_push,
  input  wire logic [WIDTH-1:0]       i_din,
  input  wire logic                   i_pop,
  output logic      [WIDTH-1:0]       o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic      [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Zero when empty so stale entries never leak out after reset or a drain.
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ring_node_adapter.sv
`default_nettype none
// ============================================================================
// Module      : ring_node_adapter
// Description : Connects a core to one ring node. Core requests are wrapped
//               into packets and queued in an injection FIFO whose head is
//               offered to the ring; packets delivered by the ring are queued
//               in an ejection FIFO and returned to the core as responses.
//               Deliveries cannot be stalled, so a delivery into a full
//               ejection FIFO is dropped and latched in ej_overflow.
// Ports       : clk    - interconnect clock
//               rst_l  - asynchronous active-low reset
//               bus    - request, ring and response signals (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module ring_node_adapter
  import ring_node_adapter_pkg::*;
#(
  parameter int NUM_PROC  = 4,
  parameter int NODE_ID   = 0,
  parameter int INJ_DEPTH = 8,
  parameter int EJ_DEPTH  = 8
) (
  input wire logic           clk,
  input wire logic           rst_l,
  ring_node_adapter_if.slave bus
);
  localparam int DW    = $clog2(NUM_PROC);
  localparam int PKT_W = $bits(pkt_t);
  localparam int EJ_W  = ID_SIZE + ADDR_W;

  pkt_t             w_req_pkt;
  logic [PKT_W-1:0] w_inj_dout;
  logic             w_inj_full;
  logic             w_inj_empty;
  logic             w_inj_push;
  logic             w_inj_pop;

  logic [EJ_W-1:0]  w_ej_din;
  logic [EJ_W-1:0]  w_ej_dout;
  logic             w_ej_full;
  logic             w_ej_empty;
  logic             w_ej_pop;
  logic             w_ej_drop;
  logic             r_ej_overflow;

  // Injection path: a request addressed to this node is forwarded as-is.
  always_comb begin
    w_req_pkt               = '0;
    w_req_pkt.src           = ID_SIZE'(NODE_ID);
    w_req_pkt.dest          = ID_SIZE'(bus.req_dest);
    w_req_pkt.memoryAddress = bus.req_addr;
  end

  // req_ready looks only at occupancy, never at a same-cycle pop.
  assign bus.req_ready    = !w_inj_full;
  assign w_inj_push       = bus.req_valid && !w_inj_full;
  assign w_inj_pop        = bus.recievedOut && !w_inj_empty;
  assign bus.packetCoreIn = !w_inj_empty;
  assign bus.packetSendIn = pkt_t'(w_inj_dout);

  sync_fifo #(.WIDTH(PKT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .i_push  (w_inj_push),
    .i_din   (PKT_W'(w_req_pkt)),
    .i_pop   (w_inj_pop),
    .o_dout  (w_inj_dout),
    .o_full  (w_inj_full),
    .o_empty (w_inj_empty),
    .o_count (bus.inj_count)
  );

  // Ejection path: only source and address are kept for the core.
  assign w_ej_din       = {bus.packetRecieved.src, bus.packetRecieved.memoryAddress};
  assign w_ej_pop       = bus.resp_ready && !w_ej_empty;
  assign w_ej_drop      = bus.recieved && w_ej_full && !w_ej_pop;
  assign bus.resp_valid = !w_ej_empty;
  assign bus.resp_src   = DW'(w_ej_dout[ADDR_W +: ID_SIZE]);
  assign bus.resp_addr  = w_ej_dout[ADDR_W-1:0];

  sync_fifo #(.WIDTH(EJ_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .i_push  (bus.recieved),
    .i_din   (w_ej_din),
    .i_pop   (w_ej_pop),
    .o_dout  (w_ej_dout),
    .o_full  (w_ej_full),
    .o_empty (w_ej_empty),
    .o_count (bus.ej_count)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ej_overflow <= 1'b0;
    end else if (w_ej_drop) begin
      r_ej_overflow <= 1'b1;
    end
  end

  assign bus.ej_overflow = r_ej_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ring_node_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_node_adapter
// Description : Directed self-checking bench for ring_node_adapter
//               (NODE_ID=1, depths 8). Expected packets and responses are
//               queued when stimulus is driven and compared when the adapter
//               presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_node_adapter;
  import ring_node_adapter_pkg::*;

  logic clk;
  logic rst_l;
  int   n_assert;
  int   n_fail;

  pkt_t            inj_q[$];
  logic [49:0]     ej_q[$];

  ring_node_adapter_if #(.NUM_PROC(4), .INJ_DEPTH(8), .EJ_DEPTH(8)) bus ();

  ring_node_adapter #(
    .NUM_PROC(4), .NODE_ID(1), .INJ_DEPTH(8), .EJ_DEPTH(8)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic pkt_t mk(input logic [1:0] s, input logic [1:0] d, input logic [47:0] a);
    pkt_t p;
    p.src = s; p.dest = d; p.memoryAddress = a;
    return p;
  endfunction

  task automatic check_head(input string tag);
    pkt_t e;
    e = inj_q.pop_front();
    check(tag, 64'(bus.packetSendIn), 64'(e));
  endtask

  task automatic check_resp(input string tag);
    logic [49:0] e;
    e = ej_q.pop_front();
    check(tag, 64'({bus.resp_src, bus.resp_addr}), 64'(e));
  endtask

  initial begin
    pkt_t tmp;
    n_assert = 0;
    n_fail   = 0;
    rst_l = 1'b0;
    bus.req_valid = 1'b0; bus.req_dest = '0; bus.req_addr = '0;
    bus.recievedOut = 1'b0; bus.recieved = 1'b0; bus.packetRecieved = '0;
    bus.resp_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) cyc();
    check("rst_inj_count", 64'(bus.inj_count), 64'd0);
    check("rst_ej_count", 64'(bus.ej_count), 64'd0);
    check("rst_core_in", 64'(bus.packetCoreIn), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_overflow", 64'(bus.ej_overflow), 64'd0);
    check("rst_send_pkt", 64'(bus.packetSendIn), 64'd0);
    check("rst_resp_data", 64'({bus.resp_src, bus.resp_addr}), 64'd0);
    rst_l = 1'b1;
    cyc();
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_no_present", 64'(bus.packetCoreIn), 64'd0);

    // ---------------- single request ----------------
    bus.req_valid = 1'b1; bus.req_dest = 2'd3; bus.req_addr = 48'h1000;
    inj_q.push_back(mk(2'd1, 2'd3, 48'h1000));
    cyc();
    bus.req_valid = 1'b0;
    check("single_core_in", 64'(bus.packetCoreIn), 64'd1);
    check("single_count", 64'(bus.inj_count), 64'd1);
    bus.recievedOut = 1'b1;
    check_head("single_head");
    cyc();
    check("single_popped", 64'(bus.inj_count), 64'd0);
    // recievedOut with nothing presented must be ignored
    cyc();
    bus.recievedOut = 1'b0;
    check("idle_pop_count", 64'(bus.inj_count), 64'd0);
    check("idle_pop_core_in", 64'(bus.packetCoreIn), 64'd0);

    // ---------------- fill injection FIFO ----------------
    for (int i = 0; i < 8; i++) begin
      check("fill_ready", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1; bus.req_dest = 2'(i); bus.req_addr = 48'h2000 + 48'(i);
      inj_q.push_back(mk(2'd1, 2'(i), 48'h2000 + 48'(i)));
      cyc();
    end
    check("full_ready", 64'(bus.req_ready), 64'd0);
    check("full_count", 64'(bus.inj_count), 64'd8);
    bus.req_addr = 48'h2008;   // 9th request offered while full
    cyc();
    bus.req_valid = 1'b0;
    check("ninth_rejected", 64'(bus.inj_count), 64'd8);
    tmp = inj_q[0];
    check("stall_head_stable", 64'(bus.packetSendIn), 64'(tmp));
    bus.recievedOut = 1'b1;
    check_head("fifo_order");
    cyc();
    bus.recievedOut = 1'b0;
    check("after_pop_ready", 64'(bus.req_ready), 64'd1);
    check("after_pop_count", 64'(bus.inj_count), 64'd7);
    bus.recievedOut = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_head("fifo_order");
      cyc();
    end
    bus.recievedOut = 1'b0;
    check("drained_count", 64'(bus.inj_count), 64'd0);

    // ---------------- simultaneous push and pop at count 1 ----------------
    bus.req_valid = 1'b1; bus.req_dest = 2'd2; bus.req_addr = 48'h3000;
    inj_q.push_back(mk(2'd1, 2'd2, 48'h3000));
    cyc();
    bus.req_dest = 2'd1; bus.req_addr = 48'h3001;   // dest == NODE_ID
    inj_q.push_back(mk(2'd1, 2'd1, 48'h3001));
    bus.recievedOut = 1'b1;
    check_head("pp_old_head");
    cyc();
    bus.req_valid = 1'b0; bus.recievedOut = 1'b0;
    check("pp_count", 64'(bus.inj_count), 64'd1);
    bus.recievedOut = 1'b1;
    check_head("pp_new_head");
    cyc();
    bus.recievedOut = 1'b0;
    check("pp_drained", 64'(bus.inj_count), 64'd0);

    // ---------------- ejection overflow ----------------
    for (int i = 0; i < 9; i++) begin
      bus.recieved = 1'b1;
      bus.packetRecieved = mk(2'd2, 2'd1, 48'h40 + 48'(i));
      if (i < 8) ej_q.push_back({2'd2, 48'h40 + 48'(i)});
      cyc();
      if (i == 0) check("ej_first_valid", 64'(bus.resp_valid), 64'd1);
    end
    bus.recieved = 1'b0;
    check("ej_full_count", 64'(bus.ej_count), 64'd8);
    check("ej_overflow_set", 64'(bus.ej_overflow), 64'd1);
    // delivery into a full FIFO with a same-cycle pop is kept
    bus.recieved = 1'b1; bus.packetRecieved = mk(2'd3, 2'd1, 48'h80);
    bus.resp_ready = 1'b1;
    check_resp("ej_resp");
    ej_q.push_back({2'd3, 48'h80});
    cyc();
    bus.recieved = 1'b0;
    check("ej_pushpop_count", 64'(bus.ej_count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_resp("ej_resp");
      cyc();
    end
    bus.resp_ready = 1'b0;
    check("ej_drained_count", 64'(bus.ej_count), 64'd0);
    check("ej_drained_valid", 64'(bus.resp_valid), 64'd0);
    check("ej_overflow_sticky", 64'(bus.ej_overflow), 64'd1);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_dest = 2'd0; bus.req_addr = 48'h500 + 48'(i);
      bus.recieved = (i < 3);
      bus.packetRecieved = mk(2'd0, 2'd1, 48'h600 + 48'(i));
      cyc();
    end
    bus.req_valid = 1'b0; bus.recieved = 1'b0;
    check("pre_rst_inj", 64'(bus.inj_count), 64'd5);
    check("pre_rst_ej", 64'(bus.ej_count), 64'd3);
    #2;
    rst_l = 1'b0;
    #1;
    check("async_rst_inj", 64'(bus.inj_count), 64'd0);
    check("async_rst_ej", 64'(bus.ej_count), 64'd0);
    check("async_rst_core_in", 64'(bus.packetCoreIn), 64'd0);
    check("async_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("async_rst_overflow", 64'(bus.ej_overflow), 64'd0);
    inj_q.delete();
    ej_q.delete();
    cyc();
    rst_l = 1'b1;
    cyc();
    check("post_rst_core_in", 64'(bus.packetCoreIn), 64'd0);
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_node_adapter.md
RING_NODE_ADAPTER -- requirements
Module: ring_node_adapter

Interface
REQ-001 Params SHALL be: NUM_PROC, default 4, ring node count; NODE_ID, default 0, this node's index; INJ_DEPTH, default 8, injection FIFO entries (power of 2); EJ_DEPTH, default 8, ejection FIFO entries (power of 2).
REQ-002 clk  in  1  interconnect clock; the design uses one clock.
REQ-003 rst_l  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  core offers a transfer request.
REQ-005 req_dest  in  $clog2(NUM_PROC)  destination node of the request.
REQ-006 req_addr  in  48  memory address of the request.
REQ-007 req_ready  out  1  adapter accepts the request this cycle.
REQ-008 packetSendIn  out  pkt_t  head packet presented to the ring node.
REQ-009 packetCoreIn  out  1  packetSendIn is valid.
REQ-010 recievedOut  in  1  ring took the presented packet this cycle.
REQ-011 recieved  in  1  ring delivers packetRecieved to this node this cycle; cannot be stalled.
REQ-012 packetRecieved  in  pkt_t  delivered packet.
REQ-013 resp_valid  out  1  a completed transfer is available to the core.
REQ-014 resp_src  out  $clog2(NUM_PROC)  source node of the completed transfer.
REQ-015 resp_addr  out  48  memory address of the completed transfer.
REQ-016 resp_ready  in  1  core consumes the response.
REQ-017 inj_count  out  $clog2(INJ_DEPTH)+1  injection FIFO occupancy.
REQ-018 ej_count  out  $clog2(EJ_DEPTH)+1  ejection FIFO occupancy.
REQ-019 ej_overflow  out  1  sticky flag: a delivered packet was dropped.

Function
REQ-020 Request handshake SHALL complete when req_valid && req_ready; req_ready = (inj_count < INJ_DEPTH), independent of a same-cycle pop.
REQ-021 Accepted request SHALL be stored as pkt_t {src=NODE_ID, dest=req_dest, memoryAddress=req_addr}; dest == NODE_ID is forwarded unchanged.
REQ-022 packetCoreIn SHALL equal (inj_count != 0); packetSendIn SHALL be the FIFO head, registered; a request accepted at edge N is presented from edge N+1.
REQ-023 Head SHALL remain stable while packetCoreIn=1 and recievedOut=0; head pops on the edge where recievedOut=1.
REQ-024 recievedOut while packetCoreIn=0 SHALL be ignored (no pop, count unchanged).
REQ-025 Simultaneous push and pop SHALL leave inj_count unchanged; with count 1, the new entry becomes head the next cycle.
REQ-026 Injection order SHALL be strict FIFO; pointers wrap modulo INJ_DEPTH.
REQ-027 On recieved=1 with ej_count < EJ_DEPTH, {packetRecieved.src, packetRecieved.memoryAddress} SHALL be written; resp_valid from the next edge.
REQ-028 On recieved=1 with ej_count == EJ_DEPTH and no same-cycle pop, the packet SHALL be dropped and ej_overflow set until reset; with a same-cycle pop it is written.
REQ-029 resp_valid = (ej_count != 0); response pops on resp_valid && resp_ready; resp_src/resp_addr stable until popped.
REQ-030 Counters SHALL never exceed depth or underflow; widths hold the value DEPTH exactly.

Reset
REQ-031 On rst_l=0, asynchronously: both FIFOs empty, inj_count=0, ej_count=0, packetCoreIn=0, resp_valid=0, ej_overflow=0, packetSendIn='0, resp_src=0, resp_addr=0, req_ready=1 after release.
REQ-032 Reset mid-operation SHALL discard all queued packets; no packet is presented on the first edge after release.

Structure
REQ-033 pkt_t, ID_SIZE, and the 48-bit address width SHALL come from the shared network package; no local redefinition.
REQ-034 One sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count), SHALL be instantiated twice: injection and ejection.

Verification
REQ-035 Reset, NODE_ID=1, push dest=3 addr=0x1000 -> next cycle packetCoreIn=1, packetSendIn={1,3,0x1000}, inj_count=1.
REQ-036 Push 8 requests with recievedOut=0 -> req_ready=0 after the 8th; 9th not accepted; release one recievedOut -> req_ready=1, order 0..7 preserved.
REQ-037 inj_count=1, push and recievedOut same cycle -> inj_count stays 1, new packet at head next cycle.
REQ-038 9 recieved pulses (src=2, addr=0x40+i) with resp_ready=0 -> ej_count=8, ej_overflow=1, 9th dropped; drain returns addrs 0x40..0x47.
REQ-039 Assert rst_l=0 mid-cycle with inj_count=5, ej_count=3 -> all counts 0, packetCoreIn=0, resp_valid=0 immediately.
